// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 16x8 synchronous first-word-fall-through FIFO for received bytes.
//            The output holds the last popped byte while the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic [4:0] cnt,
  output logic       empty
);

  logic [7:0] mem [16];
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] last_q, last_d;
  logic       do_push;
  logic       do_pop;

  always_comb begin
    do_push  = push && (cnt_q != 5'd16);
    do_pop   = pop && (cnt_q != 5'd0);
    wr_ptr_d = do_push ? wr_ptr_q + 4'd1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 4'd1 : rd_ptr_q;
    last_d   = do_pop ? mem[rd_ptr_q] : last_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 5'd1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  // Storage is left unreset; the output mux never exposes an unwritten entry.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      cnt_q    <= 5'd0;
      last_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign empty = (cnt_q == 5'd0);
  assign cnt   = cnt_q;
  assign dout  = empty ? last_q : mem[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : UART receive channel - oversampled deframer with parity/stop
//            error flags and a 16-entry receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        rx_rstn,
  input  logic [19:0] uart_buad,
  input  logic        rx,
  input  logic [3:0]  data_length,
  input  logic        check,
  input  logic        st_check,
  input  logic        parity,
  input  logic        p_error_ack,
  input  logic        st_error_ack,
  input  logic        rx_fifo_read,
  output logic        st_error,
  output logic        p_error,
  output logic [4:0]  rx_fifo_cnt,
  output logic        rx_fifo_empty,
  output logic        rx_work,
  output logic [7:0]  data_to_reg
);

  localparam logic [31:0] CLK_FREQ_U = CLK_FREQ;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] bp_q, bp_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bad_q, par_bad_d;
  logic        p_error_q, p_error_d;
  logic        st_error_q, st_error_d;
  logic        rx_meta_q, rx_sync_q, rx_last_q;

  logic [31:0] bp_calc;
  logic [31:0] half;
  logic [2:0]  last_idx;
  logic        fall;
  logic        frame_end;
  logic        stop_bad;
  logic        push;
  logic        exp_par;

  always_comb begin
    bp_calc = (uart_buad == 20'd0) ? CLK_FREQ_U : CLK_FREQ_U / {12'd0, uart_buad};
    half    = bp_q >> 1;
    fall    = rx_last_q && !rx_sync_q;
    exp_par = parity ? ~^shift_q : ^shift_q;
    case (data_length)
      4'd5:    last_idx = 3'd4;
      4'd6:    last_idx = 3'd5;
      4'd7:    last_idx = 3'd6;
      default: last_idx = 3'd7;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bp_d      = bp_q;
    cnt_d     = cnt_q + 32'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    frame_end = 1'b0;
    stop_bad  = 1'b0;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Baud changes are only picked up between frames.
        bp_d  = bp_calc;
        cnt_d = 32'd0;
        if (fall) begin
          state_d   = S_START;
          shift_d   = 8'd0;
          bit_idx_d = 3'd0;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q + 32'd1 >= half) begin
          cnt_d   = 32'd0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q + 32'd1 >= bp_q) begin
          cnt_d              = 32'd0;
          shift_d[bit_idx_q] = rx_sync_q;
          if (bit_idx_q == last_idx) begin
            state_d = check ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (cnt_q + 32'd1 >= bp_q) begin
          cnt_d     = 32'd0;
          par_bad_d = (rx_sync_q != exp_par);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q + 32'd1 >= bp_q) begin
          cnt_d     = 32'd0;
          frame_end = 1'b1;
          stop_bad  = !rx_sync_q && st_check;
          push      = !stop_bad && !par_bad_q;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A fresh error in the ack cycle takes priority over the clear.
  always_comb begin
    p_error_d  = p_error_q;
    st_error_d = st_error_q;
    if (p_error_ack)  p_error_d  = 1'b0;
    if (st_error_ack) st_error_d = 1'b0;
    if (frame_end && par_bad_q) p_error_d  = 1'b1;
    if (stop_bad)               st_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      state_q    <= S_IDLE;
      bp_q       <= 32'd0;
      cnt_q      <= 32'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_bad_q  <= 1'b0;
      p_error_q  <= 1'b0;
      st_error_q <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_last_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bp_q       <= bp_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      p_error_q  <= p_error_d;
      st_error_q <= st_error_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_last_q  <= rx_sync_q;
    end
  end

  uart_rx_fifo u_fifo (
    .clk   (clk),
    .rst_n (rx_rstn),
    .push  (push),
    .din   (shift_q),
    .pop   (rx_fifo_read),
    .dout  (data_to_reg),
    .cnt   (rx_fifo_cnt),
    .empty (rx_fifo_empty)
  );

  assign rx_work  = (state_q != S_IDLE);
  assign p_error  = p_error_q;
  assign st_error = st_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Directed self-checking bench for uart_rx_core with a byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int BIT_CLKS = 50;

  logic        clk = 1'b0;
  logic        rx_rstn = 1'b0;
  logic [19:0] uart_buad = 20'd1_000_000;
  logic        rx = 1'b1;
  logic [3:0]  data_length = 4'd8;
  logic        check = 1'b1;
  logic        st_check = 1'b1;
  logic        parity = 1'b0;
  logic        p_error_ack = 1'b0;
  logic        st_error_ack = 1'b0;
  logic        rx_fifo_read = 1'b0;
  logic        st_error;
  logic        p_error;
  logic [4:0]  rx_fifo_cnt;
  logic        rx_fifo_empty;
  logic        rx_work;
  logic [7:0]  data_to_reg;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  sb[$];
  logic [7:0]  last_popped = 8'd0;

  always #10 clk = ~clk;

  uart_rx_core #(.CLK_FREQ(50_000_000)) dut (
    .clk           (clk),
    .rx_rstn       (rx_rstn),
    .uart_buad     (uart_buad),
    .rx            (rx),
    .data_length   (data_length),
    .check         (check),
    .st_check      (st_check),
    .parity        (parity),
    .p_error_ack   (p_error_ack),
    .st_error_ack  (st_error_ack),
    .rx_fifo_read  (rx_fifo_read),
    .st_error      (st_error),
    .p_error       (p_error),
    .rx_fifo_cnt   (rx_fifo_cnt),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_work       (rx_work),
    .data_to_reg   (data_to_reg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic even_par(input logic [7:0] d, input int len);
    logic p;
    p = 1'b0;
    for (int i = 0; i < len; i++) p = p ^ d[i];
    return p;
  endfunction

  task automatic send_frame(input logic [7:0] d, input int len, input logic use_par,
                            input logic par_bit, input logic stop_bit);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < len; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS);
    end
    if (use_par) begin
      rx = par_bit;
      wait_clks(BIT_CLKS);
    end
    rx = stop_bit;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(5);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed read with empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, {24'd0, data_to_reg}, {24'd0, e});
      last_popped = e;
    end
    rx_fifo_read = 1'b1;
    @(negedge clk);
    rx_fifo_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    logic       seen;
    wait_clks(4);
    chk("rst_cnt", {27'd0, rx_fifo_cnt}, 32'd0);
    chk("rst_empty", {31'd0, rx_fifo_empty}, 32'd1);
    chk("rst_work", {31'd0, rx_work}, 32'd0);
    chk("rst_data", {24'd0, data_to_reg}, 32'd0);
    chk("rst_perr", {31'd0, p_error}, 32'd0);
    chk("rst_sterr", {31'd0, st_error}, 32'd0);
    rx_rstn = 1'b1;
    wait_clks(10);

    // Fill the FIFO with 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      send_frame(b, 8, 1'b1, even_par(b, 8), 1'b1);
      sb.push_back(b);
      chk("fill_cnt", {27'd0, rx_fifo_cnt}, 32'(sb.size()));
      chk("fill_perr", {31'd0, p_error}, 32'd0);
      chk("fill_sterr", {31'd0, st_error}, 32'd0);
    end
    chk("fill_head", {24'd0, data_to_reg}, 32'h00);

    // Two more frames while full are dropped.
    for (int i = 16; i < 18; i++) begin
      b = 8'(i);
      send_frame(b, 8, 1'b1, even_par(b, 8), 1'b1);
      chk("full_cnt", {27'd0, rx_fifo_cnt}, 32'd16);
    end

    for (int i = 0; i < 16; i++) read_check("drain_head");
    chk("drain_empty", {31'd0, rx_fifo_empty}, 32'd1);
    chk("drain_cnt", {27'd0, rx_fifo_cnt}, 32'd0);
    chk("drain_hold", {24'd0, data_to_reg}, {24'd0, last_popped});

    // Wrong parity bit on 0x03.
    send_frame(8'h03, 8, 1'b1, ~even_par(8'h03, 8), 1'b1);
    chk("perr_set", {31'd0, p_error}, 32'd1);
    chk("perr_cnt", {27'd0, rx_fifo_cnt}, 32'(sb.size()));
    wait_clks(20);
    chk("perr_sticky", {31'd0, p_error}, 32'd1);
    p_error_ack = 1'b1;
    @(negedge clk);
    p_error_ack = 1'b0;
    chk("perr_clr", {31'd0, p_error}, 32'd0);

    // Low stop bit with stop checking enabled.
    send_frame(8'h55, 8, 1'b1, even_par(8'h55, 8), 1'b0);
    chk("sterr_set", {31'd0, st_error}, 32'd1);
    chk("sterr_perr", {31'd0, p_error}, 32'd0);
    chk("sterr_cnt", {27'd0, rx_fifo_cnt}, 32'(sb.size()));
    wait_clks(20);
    chk("sterr_sticky", {31'd0, st_error}, 32'd1);
    st_error_ack = 1'b1;
    @(negedge clk);
    st_error_ack = 1'b0;
    chk("sterr_clr", {31'd0, st_error}, 32'd0);

    // Same frame with stop checking off is stored.
    st_check = 1'b0;
    send_frame(8'h55, 8, 1'b1, even_par(8'h55, 8), 1'b0);
    sb.push_back(8'h55);
    chk("nost_flag", {31'd0, st_error}, 32'd0);
    chk("nost_cnt", {27'd0, rx_fifo_cnt}, 32'(sb.size()));
    read_check("nost_head");
    st_check = 1'b1;

    // 5-bit frame, odd parity.
    data_length = 4'd5;
    parity = 1'b1;
    send_frame(8'h15, 5, 1'b1, ~even_par(8'h15, 5), 1'b1);
    sb.push_back(8'h15);
    chk("len5_perr", {31'd0, p_error}, 32'd0);
    chk("len5_cnt", {27'd0, rx_fifo_cnt}, 32'(sb.size()));
    read_check("len5_head");

    // Short low glitch on the idle line.
    seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | rx_work;
    end
    rx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | rx_work;
    end
    chk("glitch_work_seen", {31'd0, seen}, 32'd1);
    wait_clks(60);
    chk("glitch_work_end", {31'd0, rx_work}, 32'd0);
    chk("glitch_cnt", {27'd0, rx_fifo_cnt}, 32'(sb.size()));

    // Queue three bytes, raise a parity error, then reset mid-frame.
    data_length = 4'd8;
    parity = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = 8'hA0 + 8'(i);
      send_frame(b, 8, 1'b1, even_par(b, 8), 1'b1);
      sb.push_back(b);
    end
    send_frame(8'h01, 8, 1'b1, ~even_par(8'h01, 8), 1'b1);
    chk("pre_rst_cnt", {27'd0, rx_fifo_cnt}, 32'd3);
    chk("pre_rst_perr", {31'd0, p_error}, 32'd1);
    rx = 1'b0;
    wait_clks(120);
    chk("mid_work", {31'd0, rx_work}, 32'd1);
    rx_rstn = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mrst_cnt", {27'd0, rx_fifo_cnt}, 32'd0);
    chk("mrst_empty", {31'd0, rx_fifo_empty}, 32'd1);
    chk("mrst_work", {31'd0, rx_work}, 32'd0);
    chk("mrst_perr", {31'd0, p_error}, 32'd0);
    chk("mrst_sterr", {31'd0, st_error}, 32'd0);
    rx = 1'b1;
    wait_clks(3);
    rx_rstn = 1'b1;
    wait_clks(10);
    chk("post_rst_work", {31'd0, rx_work}, 32'd0);
    chk("post_rst_data", {24'd0, data_to_reg}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
